cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the ALU result port and the load/store buffer.

---
 rtl/cdb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs (ALU, LSB) sharing one registered broadcast port.
// Optional build macro CDB_FIXED_PRIO_EN gives the LSB head fixed priority instead of round-robin.

module cdb_result_fifo #(
  parameter int LAB_WIDTH = 4,
  parameter int VAL_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 clear,
  input  logic                 push,
  input  logic [LAB_WIDTH-1:0] push_lab,
  input  logic [VAL_WIDTH-1:0] push_val,
  input  logic                 pop,
  output logic                 full,
  output logic                 nonempty,
  output logic [LAB_WIDTH-1:0] head_lab,
  output logic [VAL_WIDTH-1:0] head_val
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [LAB_WIDTH-1:0] lab_mem_r [DEPTH];
  logic [VAL_WIDTH-1:0] val_mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     cnt_r;

  assign full     = (cnt_r == DEPTH_C);
  assign nonempty = (cnt_r != CNT_W'(0));
  assign head_lab = lab_mem_r[rd_ptr_r];
  assign head_val = val_mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (push && !pop)      cnt_r <= cnt_r + CNT_W'(1);
      else if (!push && pop) cnt_r <= cnt_r - CNT_W'(1);
      else                   cnt_r <= cnt_r;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      lab_mem_r[wr_ptr_r] <= push_lab;
      val_mem_r[wr_ptr_r] <= push_val;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int VAL_WIDTH = 32,
  parameter int LAB_WIDTH = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic [LAB_WIDTH-1:0] alu_lab,
  input  logic [VAL_WIDTH-1:0] alu_val,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [LAB_WIDTH-1:0] lsb_lab,
  input  logic [VAL_WIDTH-1:0] lsb_val,
  output logic                 lsb_ready,
  output logic                 cdb_en,
  output logic [LAB_WIDTH-1:0] cdb_lab,
  output logic [VAL_WIDTH-1:0] cdb_val,
  output logic                 cdb_src
);
  logic                 clear_s;
  logic                 alu_push_s, lsb_push_s;
  logic                 alu_full_s, lsb_full_s;
  logic                 alu_ne_s, lsb_ne_s;
  logic                 grant_alu_s, grant_lsb_s;
  logic [LAB_WIDTH-1:0] alu_head_lab_s, lsb_head_lab_s;
  logic [VAL_WIDTH-1:0] alu_head_val_s, lsb_head_val_s;

  assign clear_s    = rdy_in && flush;
  assign alu_ready  = rdy_in && !alu_full_s;
  assign lsb_ready  = rdy_in && !lsb_full_s;
  // Label 0 means "no tag", so such results are dropped rather than queued.
  assign alu_push_s = rdy_in && !flush && alu_valid && !alu_full_s && (alu_lab != '0);
  assign lsb_push_s = rdy_in && !flush && lsb_valid && !lsb_full_s && (lsb_lab != '0);

  cdb_result_fifo #(.LAB_WIDTH(LAB_WIDTH), .VAL_WIDTH(VAL_WIDTH), .DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst_in(rst_in), .clear(clear_s), .push(alu_push_s), .push_lab(alu_lab),
    .push_val(alu_val), .pop(grant_alu_s), .full(alu_full_s), .nonempty(alu_ne_s),
    .head_lab(alu_head_lab_s), .head_val(alu_head_val_s)
  );

  cdb_result_fifo #(.LAB_WIDTH(LAB_WIDTH), .VAL_WIDTH(VAL_WIDTH), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk(clk), .rst_in(rst_in), .clear(clear_s), .push(lsb_push_s), .push_lab(lsb_lab),
    .push_val(lsb_val), .pop(grant_lsb_s), .full(lsb_full_s), .nonempty(lsb_ne_s),
    .head_lab(lsb_head_lab_s), .head_val(lsb_head_val_s)
  );

`ifdef CDB_FIXED_PRIO_EN
  // Fixed priority: the LSB head wins whenever it is present.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsb_s = 1'b0;
    if (rdy_in && !flush) begin
      if (lsb_ne_s)      grant_lsb_s = 1'b1;
      else if (alu_ne_s) grant_alu_s = 1'b1;
      else               grant_lsb_s = 1'b0;
    end else begin
      grant_alu_s = 1'b0;
    end
  end
`else
  logic last_grant_r;  // 1 = LSB granted most recently

  // Round-robin: on contention grant the source that did not win last time.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsb_s = 1'b0;
    if (rdy_in && !flush) begin
      if (alu_ne_s && lsb_ne_s) begin
        if (last_grant_r) grant_alu_s = 1'b1;
        else              grant_lsb_s = 1'b1;
      end else if (alu_ne_s) begin
        grant_alu_s = 1'b1;
      end else if (lsb_ne_s) begin
        grant_lsb_s = 1'b1;
      end else begin
        grant_alu_s = 1'b0;
      end
    end else begin
      grant_alu_s = 1'b0;
    end
  end

  // Round-robin history; held while frozen, returned to LSB on flush.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in)          last_grant_r <= 1'b1;
    else if (clear_s)     last_grant_r <= 1'b1;
    else if (grant_alu_s) last_grant_r <= 1'b0;
    else if (grant_lsb_s) last_grant_r <= 1'b1;
    else                  last_grant_r <= last_grant_r;
  end
`endif

  // Broadcast register: cdb_en drops whenever nothing is granted so a result is never sent twice.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cdb_en  <= 1'b0;
      cdb_lab <= '0;
      cdb_val <= '0;
      cdb_src <= 1'b0;
    end else if (grant_alu_s) begin
      cdb_en  <= 1'b1;
      cdb_lab <= alu_head_lab_s;
      cdb_val <= alu_head_val_s;
      cdb_src <= 1'b0;
    end else if (grant_lsb_s) begin
      cdb_en  <= 1'b1;
      cdb_lab <= lsb_head_lab_s;
      cdb_val <= lsb_head_val_s;
      cdb_src <= 1'b1;
    end else begin
      cdb_en  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter with per-source scoreboard queues; honours CDB_FIXED_PRIO_EN.

module tb_cdb_arbiter;
  localparam int VW = 32;
  localparam int LW = 4;
`ifdef CDB_FIXED_PRIO_EN
  localparam logic FP = 1'b1;
`else
  localparam logic FP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_in, rdy_in, flush;
  logic          alu_valid, lsb_valid, alu_ready, lsb_ready;
  logic [LW-1:0] alu_lab, lsb_lab, cdb_lab;
  logic [VW-1:0] alu_val, lsb_val, cdb_val;
  logic          cdb_en, cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.VAL_WIDTH(VW), .LAB_WIDTH(LW), .DEPTH(2)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alu_valid(alu_valid), .alu_lab(alu_lab), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_lab(lsb_lab), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .cdb_en(cdb_en), .cdb_lab(cdb_lab), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  typedef struct {
    logic rdy, fl, av; logic [LW-1:0] al; logic [VW-1:0] avl;
    logic lv; logic [LW-1:0] ll; logic [VW-1:0] lvl;
    logic ear, elr, een, esrc;
  } vec_t;
  typedef struct packed { logic [LW-1:0] lab; logic [VW-1:0] val; } res_t;

  vec_t vecs[$];
  res_t alu_q[$];
  res_t lsb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, fl, av, input logic [LW-1:0] al, input logic [VW-1:0] avl,
                              input logic lv, input logic [LW-1:0] ll, input logic [VW-1:0] lvl,
                              input logic ear, elr, een, esrc);
    vec_t v;
    v.rdy = rdy; v.fl = fl; v.av = av; v.al = al; v.avl = avl;
    v.lv = lv; v.ll = ll; v.lvl = lvl;
    v.ear = ear; v.elr = elr; v.een = een; v.esrc = esrc;
    return v;
  endfunction

  task automatic idle_inputs();
    rdy_in = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_lab = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_lab = '0; lsb_val = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    res_t e;
    rdy_in = v.rdy; flush = v.fl;
    alu_valid = v.av; alu_lab = v.al; alu_val = v.avl;
    lsb_valid = v.lv; lsb_lab = v.ll; lsb_val = v.lvl;
    #1;
    check($sformatf("alu_ready[%0d]", idx), {63'd0, alu_ready}, {63'd0, v.ear});
    check($sformatf("lsb_ready[%0d]", idx), {63'd0, lsb_ready}, {63'd0, v.elr});
    if (v.rdy && !v.fl && v.av && v.ear && v.al != '0) begin
      e.lab = v.al; e.val = v.avl; alu_q.push_back(e);
    end
    if (v.rdy && !v.fl && v.lv && v.elr && v.ll != '0) begin
      e.lab = v.ll; e.val = v.lvl; lsb_q.push_back(e);
    end
    if (v.rdy && v.fl) begin
      alu_q.delete();
      lsb_q.delete();
    end
    @(posedge clk);
    #1;
    check($sformatf("cdb_en[%0d]", idx), {63'd0, cdb_en}, {63'd0, v.een});
    if (v.een) begin
      if ((v.esrc && lsb_q.size() == 0) || (!v.esrc && alu_q.size() == 0)) begin
        checks++; failures++;
        $display("FAIL scoreboard[%0d]: got broadcast lab 0x%0h expected no entry queued", idx, cdb_lab);
      end else begin
        if (v.esrc) e = lsb_q.pop_front();
        else        e = alu_q.pop_front();
        check($sformatf("cdb_lab[%0d]", idx), {60'd0, cdb_lab}, {60'd0, e.lab});
        check($sformatf("cdb_val[%0d]", idx), {32'd0, cdb_val}, {32'd0, e.val});
        check($sformatf("cdb_src[%0d]", idx), {63'd0, cdb_src}, {63'd0, v.esrc});
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b0;
    #3;
    check("reset_cdb_en",    {63'd0, cdb_en},    64'd0);
    check("reset_cdb_lab",   {60'd0, cdb_lab},   64'd0);
    check("reset_cdb_val",   {32'd0, cdb_val},   64'd0);
    check("reset_cdb_src",   {63'd0, cdb_src},   64'd0);
    check("reset_alu_ready", {63'd0, alu_ready}, 64'd1);
    check("reset_lsb_ready", {63'd0, lsb_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    @(posedge clk);
    #1;

    // contention after reset: round-robin favours ALU, fixed priority favours LSB
    vecs.push_back(mk(1, 0, 1, 4'd2, 32'hA, 1, 4'd5, 32'hB, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1, 1, FP));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1, 1, !FP));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1, 0, 0));
    // single ALU result, two-edge latency
    vecs.push_back(mk(1, 0, 1, 4'd3, 32'h11, 0, 4'd0, 32'h0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0, 1, 1, 0, 0));
    // ALU backpressure while the LSB competes; the third ALU result is re-offered until accepted
    vecs.push_back(mk(1, 0, 1, 4'd6,  32'h06, 1, 4'd7, 32'h07, 1,   1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 4'd8,  32'h08, 1, 4'd9, 32'h09, 1,   1, 1, 1));
    vecs.push_back(mk(1, 0, 1, 4'd10, 32'h0A, 0, 4'd0, 32'h0,  0,   1, 1, FP));
    vecs.push_back(mk(1, 0, 1, 4'd10, 32'h0A, 0, 4'd0, 32'h0,  !FP, 1, 1, !FP));
    vecs.push_back(mk(1, 0, FP, 4'd10, 32'h0A, 0, 4'd0, 32'h0, FP,  1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0,  32'h0,  0, 4'd0, 32'h0,  1,   1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0,  32'h0,  0, 4'd0, 32'h0,  1,   1, 0, 0));
    // flush with entries queued; same-cycle inputs are discarded
    vecs.push_back(mk(1, 0, 1, 4'd12, 32'hC, 1, 4'd14, 32'hE, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 4'd13, 32'hD, 1, 4'd15, 32'hF, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 4'd1,  32'h1, 1, 4'd1,  32'h1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0,  32'h0, 0, 4'd0,  32'h0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0,  32'h0, 0, 4'd0,  32'h0, 1, 1, 0, 0));
    // freeze for three cycles with one queued entry
    vecs.push_back(mk(1, 0, 1, 4'd4, 32'h44, 0, 4'd0, 32'h0,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 32'h0,  1, 4'd5, 32'h55, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 0, 0));
    // label 0 is dropped on both ports
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h99, 1, 4'd0, 32'h98, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 1, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);
    check("sb_alu_empty", 64'(alu_q.size()), 64'd0);
    check("sb_lsb_empty", 64'(lsb_q.size()), 64'd0);

    // asynchronous reset in the middle of a busy stream
    idle_inputs();
    alu_valid = 1'b1; alu_lab = 4'd7; alu_val = 32'h77;
    lsb_valid = 1'b1; lsb_lab = 4'd9; lsb_val = 32'h99;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_cdb_en", {63'd0, cdb_en}, 64'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check("midrst_cdb_en",  {63'd0, cdb_en},  64'd0);
    check("midrst_cdb_lab", {60'd0, cdb_lab}, 64'd0);
    check("midrst_cdb_val", {32'd0, cdb_val}, 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_in = 1'b1;
    alu_q.delete();
    lsb_q.delete();
    apply(mk(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1, 0, 0), 100);
    apply(mk(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1, 0, 0), 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
